// File: rtl/axil_lite_master.sv
// axil_lite_master: single-outstanding AXI4-Lite initiator driven by a command/response port
module axil_lite_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [7:0]              err_count,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_next;
    logic   w_next;
    logic   err_sat;

    assign cmd_ready = (state == IDLE) & m1_axi_aresetn;
    assign aw_next   = aw_done | (m1_axi_awvalid & m1_axi_awready);
    assign w_next    = w_done | (m1_axi_wvalid & m1_axi_wready);
    assign err_sat   = (err_count == 8'hFF);

    // Transaction FSM; every AXI and response output is a register
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state          <= IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            m1_axi_awaddr  <= '0;
            m1_axi_awvalid <= 1'b0;
            m1_axi_wdata   <= '0;
            m1_axi_wstrb   <= '0;
            m1_axi_wvalid  <= 1'b0;
            m1_axi_bready  <= 1'b0;
            m1_axi_araddr  <= '0;
            m1_axi_arvalid <= 1'b0;
            m1_axi_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            err_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_write) begin
                            m1_axi_awaddr  <= cmd_addr;
                            m1_axi_wdata   <= cmd_wdata;
                            m1_axi_wstrb   <= cmd_wstrb;
                            m1_axi_awvalid <= 1'b1;
                            m1_axi_wvalid  <= 1'b1;
                            aw_done        <= 1'b0;
                            w_done         <= 1'b0;
                            state          <= WR;
                        end else begin
                            m1_axi_araddr  <= cmd_addr;
                            m1_axi_arvalid <= 1'b1;
                            state          <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    // AW and W complete independently; each valid drops on its own handshake
                    m1_axi_awvalid <= m1_axi_awvalid & ~m1_axi_awready;
                    m1_axi_wvalid  <= m1_axi_wvalid & ~m1_axi_wready;
                    aw_done        <= aw_next;
                    w_done         <= w_next;
                    if (aw_next && w_next) begin
                        m1_axi_bready <= 1'b1;
                        state         <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m1_axi_bvalid) begin
                        m1_axi_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_write     <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_err       <= m1_axi_bresp;
                        err_count     <= (m1_axi_bresp && !err_sat) ? err_count + 8'd1 : err_count;
                        state         <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (m1_axi_arready) begin
                        m1_axi_arvalid <= 1'b0;
                        m1_axi_rready  <= 1'b1;
                        state          <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m1_axi_rvalid) begin
                        m1_axi_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_write     <= 1'b0;
                        rsp_rdata     <= m1_axi_rdata;
                        rsp_err       <= m1_axi_rresp;
                        err_count     <= (m1_axi_rresp && !err_sat) ? err_count + 8'd1 : err_count;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_lite_master.sv
// tb_axil_lite_master: directed checks of the AXI-Lite initiator against a scripted slave
module tb_axil_lite_master;
    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        bresp = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rresp = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_chk = 0;
    int n_err = 0;

    axil_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .m1_axi_aclk(clk), .m1_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count),
        .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
        .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
        .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
        .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
        .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic resp);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        bvalid = 1'b1; bresp = resp;
        tick();
        bvalid = 1'b0; bresp = 1'b0;
        chk("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rsp_err", {31'd0, rsp_err}, {31'd0, resp});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] d, input logic resp);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = d; rresp = resp;
        tick();
        rvalid = 1'b0; rresp = 1'b0;
        chk("rd_rsp_err", {31'd0, rsp_err}, {31'd0, resp});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
        chk("rst_awaddr", {24'd0, awaddr}, 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // zero-wait write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'd23; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("w1_awvalid", {31'd0, awvalid}, 32'd1);
        chk("w1_wvalid", {31'd0, wvalid}, 32'd1);
        chk("w1_awaddr", {24'd0, awaddr}, 32'h04);
        chk("w1_wdata", wdata, 32'd23);
        chk("w1_wstrb", {28'd0, wstrb}, 32'hF);
        chk("w1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        chk("w1_awvalid_drop", {31'd0, awvalid}, 32'd0);
        chk("w1_wvalid_drop", {31'd0, wvalid}, 32'd0);
        chk("w1_bready", {31'd0, bready}, 32'd1);
        chk("w1_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        bvalid = 1'b1; bresp = 1'b0;
        tick();
        bvalid = 1'b0;
        chk("w1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("w1_rsp_write", {31'd0, rsp_write}, 32'd1);
        chk("w1_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("w1_rsp_rdata", rsp_rdata, 32'd0);
        chk("w1_bready_drop", {31'd0, bready}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w1_rsp_done", {31'd0, rsp_valid}, 32'd0);
        chk("w1_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // write with W delayed three cycles
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h0000A5A5; cmd_wstrb = 4'h3;
        awready = 1'b1; wready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("w2_awvalid", {31'd0, awvalid}, 32'd1);
        chk("w2_wvalid_c1", {31'd0, wvalid}, 32'd1);
        tick();
        chk("w2_awvalid_drop", {31'd0, awvalid}, 32'd0);
        chk("w2_wvalid_c2", {31'd0, wvalid}, 32'd1);
        chk("w2_bready_c2", {31'd0, bready}, 32'd0);
        tick();
        chk("w2_wvalid_c3", {31'd0, wvalid}, 32'd1);
        chk("w2_wdata_c3", wdata, 32'h0000A5A5);
        tick();
        chk("w2_wvalid_c4", {31'd0, wvalid}, 32'd1);
        chk("w2_bready_c4", {31'd0, bready}, 32'd0);
        chk("w2_wstrb", {28'd0, wstrb}, 32'h3);
        wready = 1'b1;
        tick();
        chk("w2_wvalid_drop", {31'd0, wvalid}, 32'd0);
        chk("w2_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1; bresp = 1'b0;
        tick();
        bvalid = 1'b0;
        chk("w2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // read with two wait cycles, then response held off with cmd_valid high
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
        arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("r1_arvalid", {31'd0, arvalid}, 32'd1);
        chk("r1_araddr", {24'd0, araddr}, 32'h08);
        tick();
        chk("r1_arvalid_drop", {31'd0, arvalid}, 32'd0);
        chk("r1_rready", {31'd0, rready}, 32'd1);
        tick();
        tick();
        chk("r1_rready_wait", {31'd0, rready}, 32'd1);
        chk("r1_no_rsp_wait", {31'd0, rsp_valid}, 32'd0);
        rvalid = 1'b1; rdata = 32'h1E; rresp = 1'b0;
        tick();
        rvalid = 1'b0; rdata = 32'hDEADBEEF;
        chk("r1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("r1_rsp_rdata", rsp_rdata, 32'h1E);
        chk("r1_rsp_write", {31'd0, rsp_write}, 32'd0);
        chk("r1_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("r1_rready_drop", {31'd0, rready}, 32'd0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h0C;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'h1E);
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("hold_axi_valid", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hold_released", {31'd0, cmd_ready}, 32'd1);

        // error responses and err_count saturation
        do_write(8'h04, 32'd1, 1'b1);
        chk("err_count_first", {24'd0, err_count}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            do_read(8'h00, 32'd0, 1'b1);
            if (i == 252) chk("err_count_254", {24'd0, err_count}, 32'd254);
            if (i == 253) chk("err_count_255", {24'd0, err_count}, 32'd255);
        end
        chk("err_count_sat", {24'd0, err_count}, 32'd255);

        // reset while a write is in flight
        awready = 1'b0; wready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h55;
        tick();
        cmd_valid = 1'b0;
        chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("mid_rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("mid_rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        chk("mid_rst_awaddr", {24'd0, awaddr}, 32'd0);
        repeat (2) @(posedge clk);
        #3 aresetn = 1'b1;
        #1;
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("post_rst_bready", {31'd0, bready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
